// File: rtl/tx_gearbox.sv
// tx_gearbox: 64b/66b transmit gearbox. It packs 2-bit sync headers and
// 32-bit payload beats into a continuous stream of 32-bit words. Every
// 16 blocks the leftover header bits fill one extra word. On that pause
// cycle o_tx_ready drops so the upstream scrambler stalls for one cycle.
module tx_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
    input  logic                  i_tx_sync_hdr_valid,
    input  logic                  i_tx_data_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_data_valid,
    output logic                  o_align_err
);

    // Beats between pauses: each block leaves HDR_WIDTH extra bits, and a
    // full word of these extra bits is flushed once per pause.
    localparam int PAUSE_CNT = 2 * DATA_WIDTH / HDR_WIDTH;
    localparam int CW        = $clog2(PAUSE_CNT + 1);
    localparam int LW        = $clog2(DATA_WIDTH + 1);
    // The merged vector never holds more than two words. Before a header
    // beat the residual is at most DATA_WIDTH-HDR_WIDTH bits.
    localparam int EW        = 2 * DATA_WIDTH;

    logic [CW-1:0]         seq_cnt;
    logic                  parity;
    logic [DATA_WIDTH-1:0] residual;
    logic [LW-1:0]         res_len;

    logic                  pause;
    logic                  accept;
    logic [EW-1:0]         payload;
    logic [EW-1:0]         merged;
    logic [LW-1:0]         next_len;

    assign pause      = (seq_cnt == CW'(PAUSE_CNT));
    assign accept     = i_tx_data_valid && !pause;
    assign o_tx_ready = !pause;

    // Append the new beat above the residual bits. The header is placed
    // first on the wire, so it goes in the low bits of the payload.
    always_comb begin
        payload  = '0;
        next_len = res_len;
        if (!parity) begin
            payload  = EW'({i_tx_data, i_tx_sync_hdr});
            next_len = res_len + LW'(HDR_WIDTH);
        end else begin
            payload  = EW'(i_tx_data);
        end
        merged = EW'(residual) | (payload << res_len);
    end

    // Sequence counter, parity, residual store and the registered output word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_cnt         <= '0;
            parity          <= 1'b0;
            residual        <= '0;
            res_len         <= '0;
            o_tx_data       <= '0;
            o_tx_data_valid <= 1'b0;
            o_align_err     <= 1'b0;
        end else if (pause) begin
            // Flush the full word of leftover header bits. No beat is taken.
            seq_cnt         <= '0;
            residual        <= '0;
            res_len         <= '0;
            o_tx_data       <= residual;
            o_tx_data_valid <= 1'b1;
            o_align_err     <= 1'b0;
        end else if (accept) begin
            seq_cnt         <= seq_cnt + CW'(1);
            parity          <= !parity;
            residual        <= merged[DATA_WIDTH +: DATA_WIDTH];
            res_len         <= next_len;
            o_tx_data       <= merged[DATA_WIDTH-1:0];
            o_tx_data_valid <= 1'b1;
            // Report the mismatch but keep the tracked parity. The stream is
            // not resynchronised.
            o_align_err     <= (i_tx_sync_hdr_valid != !parity);
        end else begin
            o_tx_data_valid <= 1'b0;
            o_align_err     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_gearbox.sv
// tb_tx_gearbox: directed and random checks of tx_gearbox. A queue-based
// bit-serialiser builds the expected wire stream.
module tb_tx_gearbox;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_tx_data = '0;
    logic [1:0]  i_tx_sync_hdr = '0;
    logic        i_tx_sync_hdr_valid = 1'b0;
    logic        i_tx_data_valid = 1'b0;
    logic        o_tx_ready;
    logic [31:0] o_tx_data;
    logic        o_tx_data_valid;
    logic        o_align_err;

    tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_tx_data          (i_tx_data),
        .i_tx_sync_hdr      (i_tx_sync_hdr),
        .i_tx_sync_hdr_valid(i_tx_sync_hdr_valid),
        .i_tx_data_valid    (i_tx_data_valid),
        .o_tx_ready         (o_tx_ready),
        .o_tx_data          (o_tx_data),
        .o_tx_data_valid    (o_tx_data_valid),
        .o_align_err        (o_align_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    bit          q[$];
    bit          mp;
    int          mc;
    logic [31:0] last_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            if (q.size() > 0) w[i] = q.pop_front();
        end
        return w;
    endfunction

    // Run one clock cycle. Drive the inputs, then check every output
    // against the model.
    task automatic cyc(input logic v, input logic hv, input logic [1:0] hdr, input logic [31:0] d);
        logic rdy, acc, exp_err, exp_vld;
        logic [31:0] exp_w;
        rdy = (mc != 32);
        chk("ready", {63'd0, o_tx_ready}, {63'd0, rdy});
        acc = v && rdy;
        i_tx_data_valid     = v;
        i_tx_sync_hdr_valid = hv;
        i_tx_sync_hdr       = hdr;
        i_tx_data           = d;
        @(posedge i_clk);
        #1;
        exp_err = acc && (hv != !mp);
        if (acc) begin
            if (!mp) begin
                q.push_back(hdr[0]);
                q.push_back(hdr[1]);
            end
            for (int i = 0; i < 32; i++) q.push_back(d[i]);
            mp = !mp;
            mc++;
        end
        if (acc || !rdy) begin
            exp_w   = pop_word();
            exp_vld = 1'b1;
            last_w  = exp_w;
        end else begin
            exp_w   = last_w;
            exp_vld = 1'b0;
        end
        if (!rdy) begin
            mc = 0;
            chk("pause_drain", 64'(q.size()), 64'd0);
        end
        chk("valid", {63'd0, o_tx_data_valid}, {63'd0, exp_vld});
        chk("data", {32'd0, o_tx_data}, {32'd0, exp_w});
        chk("align_err", {63'd0, o_align_err}, {63'd0, exp_err});
    endtask

    // Send one beat. If the gearbox is in its pause cycle, run that cycle first.
    task automatic send(input logic hv, input logic [1:0] hdr, input logic [31:0] d);
        if (mc == 32) cyc(1'b1, hv, hdr, d);
        cyc(1'b1, hv, hdr, d);
    endtask

    task automatic do_reset();
        i_reset             = 1'b1;
        i_tx_data_valid     = 1'b1;
        i_tx_sync_hdr_valid = 1'b1;
        i_tx_data           = $urandom;
        repeat (2) begin
            @(posedge i_clk);
            #1;
            chk("rst_data", {32'd0, o_tx_data}, 64'd0);
            chk("rst_valid", {63'd0, o_tx_data_valid}, 64'd0);
            chk("rst_err", {63'd0, o_align_err}, 64'd0);
        end
        i_reset = 1'b0;
        i_tx_data_valid = 1'b0;
        q.delete();
        mp = 1'b0;
        mc = 0;
        last_w = '0;
        chk("rst_ready", {63'd0, o_tx_ready}, 64'd1);
    endtask

    initial begin
        // Reset, then the first block.
        do_reset();
        send(1'b1, 2'b01, 32'hFFFF_FFFF);
        chk("blk0_w0", {32'd0, o_tx_data}, 64'h0000_0000_FFFF_FFFD);
        send(1'b0, 2'b11, 32'h0000_0000);
        chk("blk0_w1", {32'd0, o_tx_data}, 64'h0000_0000_0000_0003);

        // Mid-stream reset with a header beat pending, then the pause.
        send(1'b1, 2'b10, 32'h1234_5678);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 2'b10, 32'h0101_0101 * k);
            send(1'b0, 2'b00, (k == 15) ? 32'hA5A5_A5A5 : ~(32'h0101_0101 * k));
        end
        chk("pause_ready_lo", {63'd0, o_tx_ready}, 64'd0);
        cyc(1'b1, 1'b1, 2'b01, 32'hDEAD_BEEF);
        chk("pause_word", {32'd0, o_tx_data}, 64'h0000_0000_A5A5_A5A5);
        chk("pause_vld", {63'd0, o_tx_data_valid}, 64'd1);
        chk("post_pause_ready", {63'd0, o_tx_ready}, 64'd1);

        // Stall for 3 cycles when the counter reaches 10.
        do_reset();
        for (int b = 0; b < 10; b++) send(b % 2 == 0, 2'b01, $urandom);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 1'b0, 2'b00, $urandom);
            chk("stall_vld", {63'd0, o_tx_data_valid}, 64'd0);
        end
        for (int b = 10; b < 32; b++) begin
            chk("stall_ready_hi", {63'd0, o_tx_ready}, 64'd1);
            send(b % 2 == 0, 2'b10, $urandom);
        end
        chk("stall_pause", {63'd0, o_tx_ready}, 64'd0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0);

        // Header valid on two consecutive beats.
        do_reset();
        send(1'b1, 2'b01, 32'hCAFE_0001);
        chk("align_first", {63'd0, o_align_err}, 64'd0);
        send(1'b1, 2'b10, 32'hCAFE_0002);
        chk("align_second", {63'd0, o_align_err}, 64'd1);
        send(1'b1, 2'b01, 32'hCAFE_0003);
        chk("align_after", {63'd0, o_align_err}, 64'd0);
        send(1'b0, 2'b11, 32'hCAFE_0004);

        // Random blocks with occasional stalls. The scoreboard checks every cycle.
        do_reset();
        for (int b = 0; b < 500; b++) begin
            for (int h = 0; h < 2; h++) begin
                if ($urandom_range(0, 7) == 0) cyc(1'b0, 1'b0, 2'($urandom), $urandom);
                send(h == 0, 2'($urandom), $urandom);
            end
        end
        repeat (2) cyc(1'b0, 1'b0, 2'b00, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/tx_gearbox.md
TX_GEARBOX -- requirements
Module: tx_gearbox

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, width of the data bus for both input beats and output words.
REQ-002 SHALL provide parameter HDR_WIDTH, default 2, width of the 64b/66b sync header.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_tx_data, input, DATA_WIDTH bits: one half of a 66b block payload from the scrambler.
REQ-006 SHALL have port i_tx_sync_hdr, input, HDR_WIDTH bits: block sync header, meaningful only when i_tx_sync_hdr_valid is high.
REQ-007 SHALL have port i_tx_sync_hdr_valid, input, 1 bit: high on the first (header) beat of each block.
REQ-008 SHALL have port i_tx_data_valid, input, 1 bit: an input beat is present.
REQ-009 SHALL have port o_tx_ready, output, 1 bit: the gearbox accepts a beat this cycle.
REQ-010 SHALL have port o_tx_data, output, DATA_WIDTH bits: the gearboxed word to the transceiver.
REQ-011 SHALL have port o_tx_data_valid, output, 1 bit: o_tx_data holds a new word.
REQ-012 SHALL have port o_align_err, output, 1 bit: one-cycle pulse flagging a header/beat-parity mismatch.

Function
REQ-013 SHALL accept a beat at a rising edge only when i_tx_data_valid and o_tx_ready are both high.
REQ-014 SHALL maintain a beat-parity bit that toggles on each accepted beat; parity 0 is the header beat, parity 1 is the second beat.
REQ-015 SHALL define the serial stream per block, transmitted LSB first, as hdr[0], hdr[1], data0[0..31], data1[0..31]: 66 bits in total.
REQ-016 SHALL emit output word n as stream bits [32n+31 : 32n], so that o_tx_data[0] is the earliest bit.
REQ-017 SHALL maintain a sequence counter, range 0..32, that increments on each accepted beat and on each pause cycle, and wraps from 32 to 0.
REQ-018 SHALL drive o_tx_ready low only while the sequence counter equals 32 (the pause cycle); 32 beats plus 1 pause equals 33 output words, equal to 16 blocks.
REQ-019 SHALL, on the pause cycle, output the 32 accumulated residual bits with o_tx_data_valid high, and accept no input.
REQ-020 SHALL register outputs with 1-cycle latency: the word produced by an accepted beat appears on o_tx_data, with o_tx_data_valid high, after the same edge that accepts the beat.
REQ-021 SHALL limit residual storage to at most 32 bits; after the pause the residual is 0 bits and the counter is 0.
REQ-022 SHALL, when o_tx_ready is high but i_tx_data_valid is low, hold the counter, parity and residual unchanged, hold o_tx_data, and drive o_tx_data_valid low.
REQ-023 SHALL pulse o_align_err for one cycle if an accepted beat has i_tx_sync_hdr_valid differing from (parity == 0).
REQ-024 SHALL, on an o_align_err, still process the beat using the tracked parity (header inserted only on parity-0 beats), and SHALL NOT resynchronise.
REQ-025 SHALL ignore i_tx_sync_hdr on parity-1 beats.

Reset
REQ-026 SHALL, while i_reset is high at an edge, set o_tx_data=0, o_tx_data_valid=0, o_align_err=0, counter=0, parity=0, residual=0.
REQ-027 SHALL drive o_tx_ready=1 in the first cycle after reset is released.
REQ-028 SHALL, on a mid-stream reset, discard any partial block and residual bits without emitting them; the first beat after reset is a header beat.

Verification
REQ-029 SHALL cover reset: assert i_reset for 2 cycles with input valid high -> o_tx_data=0, o_tx_data_valid=0, o_tx_ready=1 on release.
REQ-030 SHALL cover the first block: hdr=2'b01, data0=0xFFFFFFFF, data1=0x00000000 -> words 0xFFFFFFFD then 0x00000003.
REQ-031 SHALL cover the pause: stream 32 consecutive valid beats -> o_tx_ready=0 exactly in cycle 33, o_tx_data_valid=1 with the residual word, and o_tx_ready=1 again in cycle 34.
REQ-032 SHALL cover a stall: drop i_tx_data_valid for 3 cycles at counter=10 -> o_tx_data_valid=0 for those cycles, and the pause still occurs after 32 accepted beats.
REQ-033 SHALL cover alignment: hdr_valid high on two consecutive beats -> o_align_err pulses once, on the second beat.
REQ-034 SHALL cover the scoreboard: 500 random blocks -> a reference bit-serialiser matches every o_tx_data word, including across the counter wrap.
